// File: rtl/imem_loader.sv
// imem_loader
//   Receives a framed byte stream, packs the data bytes big-endian into 32-bit
//   instruction words and drives the instruction-memory write port. The CPU is
//   held in reset until a complete image with a matching XOR checksum has been
//   written.
//
//   Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes, CSUM (XOR of data).
//
// Ports
//   clk       system clock (rising edge)
//   rst       asynchronous active-high reset
//   start     one-cycle pulse that begins a load (ignored while busy)
//   rx_valid  source presents a byte on rx_data
//   rx_data   stream byte
//   rx_ready  loader accepts a byte; transfer on rx_valid && rx_ready
//   we        instruction memory write enable (one-cycle pulse)
//   waddr     word address of the write
//   wdata     instruction word of the write
//   cpu_hold  holds the CPU in reset while high
//   busy      a load is in progress
//   done      last load succeeded (level)
//   err       last load failed (level)
//   wcount    words written in the current or last load
module imem_loader #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [11:0]       wcount
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t              state_q;
  logic [15:0]         len_q;
  logic [1:0]          lane_q;
  logic [7:0]          csum_q;
  logic [23:0]         asm_q;     // first three bytes of the word being assembled
  logic                rx_ready_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic                cpu_hold_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [11:0]         wcount_q;

  logic                xfer;
  logic [15:0]         len_full;

  assign xfer     = rx_valid && rx_ready_q;
  assign len_full = {len_q[15:8], rx_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      lane_q     <= '0;
      csum_q     <= '0;
      asm_q      <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wcount_q   <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q    <= S_LEN_HI;
            rx_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wcount_q   <= '0;
            waddr_q    <= '0;
            csum_q     <= '0;
            lane_q     <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= rx_data;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= rx_data;
            if (len_full == 16'd0 || {1'b0, len_full} > DEPTH_L) begin
              state_q    <= S_ERR;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Write cycle: wcount already counts this word, so equality with
          // the length marks the final write. The address only advances
          // between words, so it never points past DEPTH-1.
          if (we_q) begin
            if ({4'd0, wcount_q} == len_q) begin
              state_q    <= S_CSUM;
              rx_ready_q <= 1'b1;
            end else begin
              waddr_q <= waddr_q + 1'b1;
            end
          end
          if (xfer) begin
            csum_q <= csum_q ^ rx_data;
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              we_q     <= 1'b1;
              wdata_q  <= {asm_q, rx_data};
              wcount_q <= wcount_q + 12'd1;
              // Stall the stream during the final write so the checksum
              // byte cannot slip in ahead of it.
              if ({4'd0, wcount_q} + 16'd1 == len_q) begin
                rx_ready_q <= 1'b0;
              end
            end else begin
              asm_q <= {asm_q[15:0], rx_data};
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (rx_data == csum_q) begin
              state_q    <= S_DONE;
              cpu_hold_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wcount   = wcount_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven frames, randomized frames against a
// frame-level reference model, and hand-written reset/abort sequences.
module tb_imem_loader;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [11:0]       wcount;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .wcount(wcount)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  typedef struct {
    logic [7:0]  hi, lo;
    logic [31:0] w0, w1;
    logic [7:0]  cs;
    int          mode;
    int          start_at;
    bit          exp_done, exp_err;
    int          exp_wc;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cur_n = 0;
  wr_t  wq[$];   // writes observed on the memory port
  wr_t  ew[$];   // writes expected by the model
  bit   m_done, m_err;
  int   m_wcount;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Port monitor: collects writes and checks the cycle-level invariants.
  initial begin
    bit prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_we = 1'b0;
      end else begin
        if (we) wq.push_back('{waddr, wdata});
        check("we_not_back_to_back", {31'd0, we && prev_we}, 32'd0);
        check("done_err_exclusive", {31'd0, done && err}, 32'd0);
        if (we && int'(waddr) == cur_n - 1)
          check("rx_ready_low_on_last_write", {31'd0, rx_ready}, 32'd0);
        prev_we = we;
      end
    end
  end

  // Reference model: interprets the frame directly from the framing rules.
  task automatic run_model(input bq_t b);
    int n;
    logic [7:0] x;
    ew.delete();
    n = {b[0], b[1]};
    if (n == 0 || n > DEPTH) begin
      m_done = 1'b0; m_err = 1'b1; m_wcount = 0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.a = ADDR_W'(i);
      w.d = {b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]};
      ew.push_back(w);
      for (int k = 0; k < 4; k++) x = x ^ b[2+4*i+k];
    end
    m_wcount = n;
    m_done   = (b[2+4*n] == x);
    m_err    = !m_done;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0: rx_valid held high, 1: toggling, 2: random
  task automatic send_bytes(input bq_t b, input int mode, input int start_at);
    int i = 0;
    int cyc = 0;
    bit ph = 1'b0;
    int limit = 8 * b.size() + 50;
    while (i < b.size() && cyc < limit) begin
      @(negedge clk);
      ph = ~ph;
      case (mode)
        0:       rx_valid = 1'b1;
        1:       rx_valid = ph;
        default: rx_valid = ($urandom_range(0, 1) == 1);
      endcase
      rx_data = b[i];
      start   = (cyc == start_at);
      if (rx_valid && rx_ready) i++;
      cyc++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    check("bytes_consumed", i, b.size());
  endtask

  task automatic run_frame(input string name, input bq_t b, input int mode, input int start_at);
    int lim;
    run_model(b);
    cur_n = m_wcount;
    wq.delete();
    do_start();
    check({name, ".busy_after_start"}, {31'd0, busy}, 32'd1);
    send_bytes(b, mode, start_at);
    lim = 0;
    while (busy && lim < 20) begin
      @(negedge clk);
      lim++;
    end
    check({name, ".idle_timeout"}, {31'd0, busy}, 32'd0);
    check({name, ".done"}, {31'd0, done}, {31'd0, m_done});
    check({name, ".err"}, {31'd0, err}, {31'd0, m_err});
    check({name, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !m_done});
    check({name, ".rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({name, ".wcount"}, {20'd0, wcount}, m_wcount);
    check({name, ".nwrites"}, wq.size(), ew.size());
    for (int i = 0; i < wq.size() && i < ew.size(); i++) begin
      check({name, ".waddr"}, {21'd0, wq[i].a}, {21'd0, ew[i].a});
      check({name, ".wdata"}, wq[i].d, ew[i].d);
    end
    $display("frame %s n=%0d writes=%0d done=%0b err=%0b wcount=%0d",
             name, m_wcount, wq.size(), done, err, wcount);
  endtask

  initial begin
    vec_t vt[5];
    bq_t  b;

    // Reset state and IDLE behaviour
    repeat (3) @(negedge clk);
    check("rst.cpu_hold_during", {31'd0, cpu_hold}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst.rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst.we", {31'd0, we}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.err", {31'd0, err}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.wcount", {20'd0, wcount}, 32'd0);
    check("rst.waddr", {21'd0, waddr}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = 8'hA5;
      @(negedge clk);
      check("idle.rx_ready", {31'd0, rx_ready}, 32'd0);
      check("idle.busy", {31'd0, busy}, 32'd0);
    end
    rx_valid = 1'b0;
    $display("reset sequence complete");

    // Directed vectors
    vt[0] = '{8'h00, 8'h02, 32'h20080005, 32'h00000000, 8'h2D, 0, -1, 1'b1, 1'b0, 2};
    vt[1] = '{8'h00, 8'h02, 32'h20080005, 32'h00000000, 8'h2C, 0, -1, 1'b0, 1'b1, 2};
    vt[2] = '{8'h00, 8'h00, 32'h0, 32'h0, 8'h00, 0, -1, 1'b0, 1'b1, 0};
    vt[3] = '{8'h08, 8'h01, 32'h0, 32'h0, 8'h00, 0, -1, 1'b0, 1'b1, 0};
    vt[4] = '{8'h00, 8'h02, 32'h20080005, 32'h00000000, 8'h2D, 1, 6, 1'b1, 1'b0, 2};
    for (int v = 0; v < 5; v++) begin
      b.delete();
      b.push_back(vt[v].hi);
      b.push_back(vt[v].lo);
      if ({vt[v].hi, vt[v].lo} == 16'd2) begin
        for (int k = 3; k >= 0; k--) b.push_back(vt[v].w0[8*k +: 8]);
        for (int k = 3; k >= 0; k--) b.push_back(vt[v].w1[8*k +: 8]);
        b.push_back(vt[v].cs);
      end
      run_frame($sformatf("vec%0d", v), b, vt[v].mode, vt[v].start_at);
      check($sformatf("vec%0d.tbl_done", v), {31'd0, done}, {31'd0, vt[v].exp_done});
      check($sformatf("vec%0d.tbl_err", v), {31'd0, err}, {31'd0, vt[v].exp_err});
      check($sformatf("vec%0d.tbl_wcount", v), {20'd0, wcount}, vt[v].exp_wc);
    end

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int n;
      logic [7:0] x;
      b.delete();
      x = 8'h00;
      if (f == 7) begin
        n = $urandom_range(DEPTH + 1, 65535);
        b.push_back(n[15:8]); b.push_back(n[7:0]);
      end else begin
        n = $urandom_range(1, 8);
        b.push_back(n[15:8]); b.push_back(n[7:0]);
        for (int k = 0; k < 4 * n; k++) begin
          logic [7:0] d;
          d = 8'($urandom_range(0, 255));
          b.push_back(d);
          x = x ^ d;
        end
        if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
        b.push_back(x);
      end
      run_frame($sformatf("rnd%0d", f), b, $urandom_range(0, 2), -1);
    end

    // Full-size image: N = DEPTH
    begin
      logic [7:0] x;
      b.delete();
      x = 8'h00;
      b.push_back(8'(DEPTH >> 8)); b.push_back(8'(DEPTH));
      for (int k = 0; k < 4 * DEPTH; k++) begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        b.push_back(d);
        x = x ^ d;
      end
      b.push_back(x);
      run_frame("full", b, 0, -1);
    end

    // Reset in the middle of a load
    b.delete();
    b = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cur_n = 2;
    do_start();
    send_bytes(b, 0, -1);
    #3 rst = 1'b1;
    #1;
    check("abort.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("abort.wcount", {20'd0, wcount}, 32'd0);
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.rx_ready", {31'd0, rx_ready}, 32'd0);
    check("abort.we", {31'd0, we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("abort sequence complete");
    b.delete();
    b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    run_frame("reload", b, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequential writer for the instruction memory.
- Receives a framed byte stream (for example from a UART receiver), packs the bytes big-endian into 32-bit MIPS instruction words, and drives the instruction memory write port.
- Holds the CPU in reset until a complete image with a valid checksum has been written.
- Sits between the byte-stream source and the instruction memory's write side.

Parameters:
- ADDR_W, 11, word-address width of the instruction memory.
- DEPTH, 2048, number of 32-bit words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load.
- rx_valid  input  1  source has a byte on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader can accept a byte; a byte transfers on any clock edge where rx_valid && rx_ready.
- we  output  1  instruction memory write enable, one-cycle pulse.
- waddr  output  ADDR_W  word address for the write.
- wdata  output  32  instruction word for the write.
- cpu_hold  output  1  holds the CPU in reset while high.
- busy  output  1  a load is in progress.
- done  output  1  the last load succeeded; level signal.
- err  output  1  the last load failed; level signal.
- wcount  output  12  number of words written in the current or last load.

Behaviour:
- Reset values (asynchronous): state=IDLE, rx_ready=0, we=0, waddr=0, wdata=0, cpu_hold=1, busy=0, done=0, err=0, wcount=0, internal length/byte-lane/checksum registers=0.
- Frame format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - 4*N data bytes. Each word is big-endian: the first byte goes to wdata[31:24].
  - CSUM: one byte equal to the XOR of all 4*N data bytes. The header is excluded.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE:
  - start -> LEN_HI.
  - On entry to LEN_HI: cpu_hold=1, busy=1, done=0, err=0, wcount=0, waddr=0, checksum=0, byte lane=0.
- rx_ready is 1 exactly in LEN_HI, LEN_LO, DATA and CSUM, and 0 in every other state.
  - Bytes presented while rx_ready=0 are not consumed.
  - rx_valid may be held across idle cycles.
- LEN_HI: on a transfer, capture len[15:8] -> LEN_LO.
- LEN_LO: on a transfer, capture len[7:0]. Then evaluate the full length:
  - N==0 or N>DEPTH -> ERR.
  - Otherwise -> DATA.
- DATA:
  - Each transfer shifts the byte into the word assembly register and XORs it into the checksum.
  - On the 4th byte of a word:
    - The next cycle has we=1, wdata=assembled word, waddr=current word index.
    - waddr increments after the write; wcount increments in the same cycle as we.
  - we is never high for two consecutive cycles.
  - Byte throughput is one per cycle. Back-to-back bytes with rx_valid held high must not be dropped; byte assembly continues while we is high.
  - After the write of word N-1 -> CSUM.
  - rx_ready must stay 0 in the we cycle of the final word, so the CSUM byte is not accepted before the last write issues.
- CSUM: on a transfer:
  - byte==checksum -> DONE.
  - Otherwise -> ERR.
- DONE: cpu_hold=0, busy=0, done=1.
- ERR: cpu_hold=1, busy=0, err=1.
- In DONE or ERR, start restarts the load exactly as from IDLE.
- While busy, start is ignored.
- A reset mid-load aborts immediately to IDLE with cpu_hold=1. Already-written memory words are not cleared.
- Width rules:
  - waddr is ADDR_W bits and never exceeds DEPTH-1, because N>DEPTH is rejected.
  - wcount is 12 bits and reaches 2048 for a full image with the default parameters.
- done and err are never both 1.

Test Plan:
- Reset -> cpu_hold=1, rx_ready=0, we=0, done=0, err=0, wcount=0; bytes offered in IDLE are not consumed.
- start, then stream 00 02 | 20 08 00 05 | 00 00 00 00 | checksum 2D, back-to-back:
  - we pulses twice: (waddr=0, wdata=32'h20080005) and (waddr=1, wdata=32'h00000000).
  - Then done=1, cpu_hold=0, wcount=2.
- Same frame with checksum 2C -> both words written, then err=1, done=0, cpu_hold=1.
- Header 00 00 -> ERR right after LEN_LO, no we pulse. Header 08 01 (N=2049) -> ERR, no we pulse.
- Stream with rx_valid toggling 1/0 every cycle, plus a start pulse during DATA -> identical writes to the back-to-back case; the start pulse is ignored.
- Reset asserted after 6 data bytes -> immediate IDLE, cpu_hold=1, wcount=0. A following start reloads cleanly from waddr=0.
